// File: rtl/pic_int_sequencer_if.sv
// Bus bundle between the interrupt sequencer and its surroundings (IRR, CPU
// acknowledge logic, command decoder, data bus driver).
//
// Handshake: the sequencer raises int_out one cycle after an eligible request
// appears and holds it until the first rising edge of inta. That edge latches
// the winner into the ISR and drops int_out. The second rising edge of inta
// drives the vector (data_en=1), and the falling edge of that pulse releases
// the bus and ends the acknowledge cycle. No further request is taken until
// the sequencer has spent at least one cycle back in IDLE.
interface pic_int_sequencer_if;
    logic [7:0] irr;
    logic       inta;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       rotate;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] isr;
    logic       reset_irr_bit;
    logic [7:0] data_out;
    logic       data_en;
    logic [2:0] cur_level;
    logic [1:0] state_dbg;
    logic [2:0] lowest_prio_dbg;

    modport slave (
        input  irr, inta, eoi, eoi_specific, eoi_level, rotate, aeoi, vector_base,
        output int_out, isr, reset_irr_bit, data_out, data_en, cur_level,
        output state_dbg, lowest_prio_dbg
    );

    modport master (
        output irr, inta, eoi, eoi_specific, eoi_level, rotate, aeoi, vector_base,
        input  int_out, isr, reset_irr_bit, data_out, data_en, cur_level,
        input  state_dbg, lowest_prio_dbg
    );
endinterface

// File: rtl/pic_int_sequencer.sv
// Interrupt controller sequencer: rotating-priority resolution, fully nested
// eligibility against the ISR, the INT/INTA two-pulse acknowledge sequence,
// and EOI / auto-EOI retirement of in-service levels.
module pic_int_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
    parameter logic [2:0] ROTATE_RESET   = 3'd7
) (
    input  logic               clk,
    input  logic               reset,
    pic_int_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       inta_q;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lowest_prio_q, lowest_prio_d;
    logic       int_out_q, int_out_d;
    logic       reset_irr_q, reset_irr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_en_q, data_en_d;
    logic [2:0] cur_level_q, cur_level_d;
    logic       spurious_q, spurious_d;

    logic       inta_rise, inta_fall;
    logic [2:0] shift;
    logic [3:0] isr_rank, irr_rank;
    logic       win_valid;
    logic [2:0] win_level, isr_top;
    logic [7:0] set_mask, aeoi_clr, eoi_clr;
    logic       eoi_hit;
    logic [2:0] eoi_lvl;

    // Rotate right so that bit 0 of the result is the highest-priority level.
    function automatic logic [7:0] rot_by(input logic [7:0] v, input logic [2:0] sh);
        logic [15:0] d;
        d = {v, v} >> sh;
        return d[7:0];
    endfunction

    // Rank (0 = highest priority) of the first set bit; 8 when none is set.
    function automatic logic [3:0] first_set(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign inta_rise = bus.inta & ~inta_q;
    assign inta_fall = ~bus.inta & inta_q;

    // Priority resolution: a request wins only if it outranks every in-service level.
    always_comb begin
        shift     = lowest_prio_q + 3'd1;
        isr_rank  = first_set(rot_by(isr_q, shift));
        irr_rank  = first_set(rot_by(bus.irr, shift));
        win_valid = irr_rank < isr_rank;
        win_level = irr_rank[2:0] + shift;
        isr_top   = isr_rank[2:0] + shift;
    end

    // State and output registers; reset aborts any acknowledge cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            inta_q        <= 1'b0;
            isr_q         <= 8'h00;
            lowest_prio_q <= ROTATE_RESET;
            int_out_q     <= 1'b0;
            reset_irr_q   <= 1'b0;
            data_out_q    <= 8'h00;
            data_en_q     <= 1'b0;
            cur_level_q   <= 3'd0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            inta_q        <= bus.inta;
            isr_q         <= isr_d;
            lowest_prio_q <= lowest_prio_d;
            int_out_q     <= int_out_d;
            reset_irr_q   <= reset_irr_d;
            data_out_q    <= data_out_d;
            data_en_q     <= data_en_d;
            cur_level_q   <= cur_level_d;
            spurious_q    <= spurious_d;
        end
    end

    // Acknowledge sequencing: next state, ISR set/auto-clear masks and bus outputs.
    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        reset_irr_d = 1'b0;
        data_out_d  = data_out_q;
        data_en_d   = data_en_q;
        cur_level_d = cur_level_q;
        spurious_d  = spurious_q;
        set_mask    = 8'h00;
        aeoi_clr    = 8'h00;
        case (state_q)
            IDLE: begin
                int_out_d = 1'b0;
                if (win_valid) begin
                    int_out_d = 1'b1;
                    state_d   = PEND;
                end
            end
            PEND: begin
                // The winner is taken from irr as it stands at the first INTA edge.
                if (inta_rise) begin
                    int_out_d = 1'b0;
                    state_d   = ACK1;
                    if (win_valid) begin
                        set_mask    = 8'h01 << win_level;
                        reset_irr_d = 1'b1;
                        cur_level_d = win_level;
                        spurious_d  = 1'b0;
                    end else begin
                        cur_level_d = SPURIOUS_LEVEL;
                        spurious_d  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    data_out_d = {bus.vector_base, cur_level_q};
                    data_en_d  = 1'b1;
                    state_d    = ACK2;
                end
            end
            ACK2: begin
                if (inta_fall) begin
                    data_out_d = 8'h00;
                    data_en_d  = 1'b0;
                    state_d    = IDLE;
                    if (bus.aeoi && !spurious_q) aeoi_clr = 8'h01 << cur_level_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EOI handling and ISR update: clears first, then the acknowledge set wins.
    always_comb begin
        eoi_hit = 1'b0;
        eoi_lvl = 3'd0;
        eoi_clr = 8'h00;
        if (bus.eoi) begin
            if (bus.eoi_specific) begin
                eoi_hit = 1'b1;
                eoi_lvl = bus.eoi_level;
            end else if (|isr_q) begin
                eoi_hit = 1'b1;
                eoi_lvl = isr_top;
            end
        end
        if (eoi_hit) eoi_clr = 8'h01 << eoi_lvl;
        lowest_prio_d = (eoi_hit && bus.rotate) ? eoi_lvl : lowest_prio_q;
        isr_d         = (isr_q & ~(eoi_clr | aeoi_clr)) | set_mask;
    end

    assign bus.int_out         = int_out_q;
    assign bus.isr             = isr_q;
    assign bus.reset_irr_bit   = reset_irr_q;
    assign bus.data_out        = data_out_q;
    assign bus.data_en         = data_en_q;
    assign bus.cur_level       = cur_level_q;
    assign bus.state_dbg       = state_q;
    assign bus.lowest_prio_dbg = lowest_prio_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Bench for pic_int_sequencer: cycle-by-cycle vector table with hand-computed
// outputs, followed by a hand-written back-to-back / EOI collision sequence.
module tb_pic_int_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pic_int_sequencer_if bus();

    pic_int_sequencer #(
        .SPURIOUS_LEVEL(3'd7),
        .ROTATE_RESET  (3'd7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       rst;
        logic [7:0] irr;
        logic       inta;
        logic       eoi;
        logic       spec;
        logic [2:0] elvl;
        logic       rot;
        logic       aeoi;
        logic       e_int;
        logic [7:0] e_isr;
        logic       e_rib;
        logic [7:0] e_do;
        logic       e_de;
        logic [2:0] e_cl;
        logic [2:0] e_lp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic [7:0] irr, input logic inta,
                       input logic eoi, input logic spec, input logic [2:0] elvl,
                       input logic rot, input logic aeoi,
                       input logic e_int, input logic [7:0] e_isr, input logic e_rib,
                       input logic [7:0] e_do, input logic e_de, input logic [2:0] e_cl,
                       input logic [2:0] e_lp);
        vec_t v;
        v.rst = rst; v.irr = irr; v.inta = inta; v.eoi = eoi; v.spec = spec;
        v.elvl = elvl; v.rot = rot; v.aeoi = aeoi;
        v.e_int = e_int; v.e_isr = e_isr; v.e_rib = e_rib; v.e_do = e_do;
        v.e_de = e_de; v.e_cl = e_cl; v.e_lp = e_lp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [7:0] irr, input logic inta,
                         input logic eoi, input logic spec, input logic [2:0] elvl,
                         input logic rot, input logic aeoi);
        reset            = rst;
        bus.irr          = irr;
        bus.inta         = inta;
        bus.eoi          = eoi;
        bus.eoi_specific = spec;
        bus.eoi_level    = elvl;
        bus.rotate       = rot;
        bus.aeoi         = aeoi;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bounded wait for int_out; an expired budget counts as a failed check.
    task automatic wait_int(input string name, input int budget);
        int n;
        n = 0;
        while (bus.int_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, {31'd0, bus.int_out}, 32'd1);
    endtask

    initial begin
        bus.vector_base = 5'h08;
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // rst irr inta eoi spec elvl rot aeoi | int isr rib do de cl lp
        // Basic cycle
        add(1, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h04, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h04, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h04, 1, 0, 0, 3'd0, 0, 0,  0, 8'h04, 1, 8'h00, 0, 3'd2, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h04, 0, 8'h00, 0, 3'd2, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h04, 0, 8'h00, 0, 3'd2, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h04, 0, 8'h42, 1, 3'd2, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h04, 0, 8'h42, 1, 3'd2, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h04, 0, 8'h00, 0, 3'd2, 3'd7);
        add(0, 8'h00, 0, 1, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd2, 3'd7);
        // Nesting: IR3 in service blocks IR4, IR1 nests above it
        add(0, 8'h08, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd2, 3'd7);
        add(0, 8'h08, 1, 0, 0, 3'd0, 0, 0,  0, 8'h08, 1, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h43, 1, 3'd3, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h10, 0, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h10, 0, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h02, 0, 0, 0, 3'd0, 0, 0,  1, 8'h08, 0, 8'h00, 0, 3'd3, 3'd7);
        add(0, 8'h02, 1, 0, 0, 3'd0, 0, 0,  0, 8'h0A, 1, 8'h00, 0, 3'd1, 3'd7);
        add(0, 8'h10, 0, 0, 0, 3'd0, 0, 0,  0, 8'h0A, 0, 8'h00, 0, 3'd1, 3'd7);
        add(0, 8'h10, 1, 0, 0, 3'd0, 0, 0,  0, 8'h0A, 0, 8'h41, 1, 3'd1, 3'd7);
        add(0, 8'h10, 0, 0, 0, 3'd0, 0, 0,  0, 8'h0A, 0, 8'h00, 0, 3'd1, 3'd7);
        add(0, 8'h10, 0, 1, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd1, 3'd7);
        add(0, 8'h10, 0, 0, 0, 3'd0, 0, 0,  0, 8'h08, 0, 8'h00, 0, 3'd1, 3'd7);
        add(0, 8'h00, 0, 1, 1, 3'd3, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd1, 3'd7);
        // Rotation: IR0 becomes lowest, IR7 then beats IR0
        add(1, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h01, 1, 0, 0, 3'd0, 0, 0,  0, 8'h01, 1, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h40, 1, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 1, 0, 3'd0, 1, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd0);
        add(0, 8'h81, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd0);
        add(0, 8'h81, 1, 0, 0, 3'd0, 0, 0,  0, 8'h80, 1, 8'h00, 0, 3'd7, 3'd0);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  0, 8'h80, 0, 8'h00, 0, 3'd7, 3'd0);
        add(0, 8'h01, 1, 0, 0, 3'd0, 0, 0,  0, 8'h80, 0, 8'h47, 1, 3'd7, 3'd0);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  0, 8'h80, 0, 8'h00, 0, 3'd7, 3'd0);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  0, 8'h80, 0, 8'h00, 0, 3'd7, 3'd0);
        add(0, 8'h01, 0, 1, 1, 3'd7, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd7, 3'd0);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd7, 3'd0);
        // Mid-op reset in ACK1, then a stray inta pulse in IDLE
        add(0, 8'h01, 1, 0, 0, 3'd0, 0, 0,  0, 8'h01, 1, 8'h00, 0, 3'd0, 3'd0);
        add(1, 8'h01, 1, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        // Spurious: request withdrawn before INTA1
        add(1, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h20, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd7, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd7, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h47, 1, 3'd7, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd7, 3'd7);
        // Auto-EOI, then specific EOI colliding with the ISR set
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 1,  1, 8'h00, 0, 8'h00, 0, 3'd7, 3'd7);
        add(0, 8'h01, 1, 0, 0, 3'd0, 0, 1,  0, 8'h01, 1, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 1,  0, 8'h01, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 1,  0, 8'h01, 0, 8'h40, 1, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 1,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h01, 0, 0, 0, 3'd0, 0, 0,  1, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h01, 1, 1, 1, 3'd0, 0, 0,  0, 8'h01, 1, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h40, 1, 3'd0, 3'd7);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0,  0, 8'h01, 0, 8'h00, 0, 3'd0, 3'd7);
        add(0, 8'h00, 0, 1, 1, 3'd0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd7);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].irr, vecs[i].inta, vecs[i].eoi,
                  vecs[i].spec, vecs[i].elvl, vecs[i].rot, vecs[i].aeoi);
            step();
            check($sformatf("vec%0d", i),
                  {7'd0, bus.int_out, bus.isr, bus.reset_irr_bit, bus.data_out,
                   bus.data_en, bus.cur_level, bus.lowest_prio_dbg},
                  {7'd0, vecs[i].e_int, vecs[i].e_isr, vecs[i].e_rib, vecs[i].e_do,
                   vecs[i].e_de, vecs[i].e_cl, vecs[i].e_lp});
        end

        // Back-to-back acknowledge cycles with a same-cycle EOI + auto-EOI clear
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        wait_int("seq_int_raise", 8);
        bus.inta = 1'b1;
        step();
        check("seq_isr_ir3", {24'd0, bus.isr}, 32'h08);
        bus.inta = 1'b0;
        bus.irr  = 8'h00;
        step();
        bus.inta = 1'b1;
        step();
        check("seq_vec_ir3", {23'd0, bus.data_en, bus.data_out}, 32'h143);
        bus.inta = 1'b0;
        bus.irr  = 8'h02;
        step();
        check("seq_idle_gap", {29'd0, bus.state_dbg, bus.int_out}, 32'h0);
        step();
        check("seq_b2b_int", {31'd0, bus.int_out}, 32'd1);
        bus.aeoi = 1'b1;
        bus.inta = 1'b1;
        step();
        check("seq_isr_ir1", {21'd0, bus.cur_level, bus.isr}, {21'd0, 3'd1, 8'h0A});
        bus.inta = 1'b0;
        bus.irr  = 8'h00;
        step();
        bus.inta = 1'b1;
        step();
        check("seq_vec_ir1", {24'd0, bus.data_out}, 32'h41);
        bus.inta         = 1'b0;
        bus.eoi          = 1'b1;
        bus.eoi_specific = 1'b1;
        bus.eoi_level    = 3'd3;
        step();
        bus.eoi  = 1'b0;
        bus.aeoi = 1'b0;
        check("seq_eoi_aeoi_both", {23'd0, bus.data_en, bus.isr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
- Control block for the interrupt controller: priority resolution, INT/INTA handshake sequencing and in-service register (ISR) ownership.
- Consumes the masked request vector from the IRR, picks a winner, and raises INT.
- Over a two-pulse INTA cycle it sets the ISR bit, commands the IRR to clear that bit, drives the vector, and retires the ISR bit on EOI or auto-EOI.

Parameters:
- SPURIOUS_LEVEL, 7, level reported and vectored when no request is valid at the first INTA edge. No ISR bit is set in that case.
- ROTATE_RESET, 7, reset value of the lowest-priority pointer. With 7, IR0 has the highest priority.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- irr  input  8  masked request vector from the IRR.
- inta  input  1  CPU acknowledge, active-high level, already synchronous to clk.
- eoi  input  1  one-cycle EOI command pulse.
- eoi_specific  input  1  qualifies eoi: 1 = clear level eoi_level; 0 = non-specific.
- eoi_level  input  3  level cleared by a specific EOI.
- rotate  input  1  qualifies eoi: 1 = the cleared level becomes lowest priority.
- aeoi  input  1  auto-EOI mode; sampled when the second INTA pulse ends.
- vector_base  input  5  upper vector bits T7..T3.
- int_out  output  1  interrupt request to the CPU.
- isr  output  8  in-service register; also fed back to the IRR.
- reset_irr_bit  output  1  one-cycle pulse; the IRR clears irr & isr.
- data_out  output  8  vector byte.
- data_en  output  1  data_out valid/drive enable.
- cur_level  output  3  level latched at the first INTA edge.

Behaviour:
- Reset: all outputs and state clear to 0, FSM to IDLE, lowest_prio = ROTATE_RESET. Reset overrides any in-flight cycle; int_out drops on the next edge.
- Priority: highest priority level = (lowest_prio+1) mod 8, descending cyclically from there.
- Eligibility: an irr bit is eligible if its priority is strictly higher than every set isr bit (fully nested). An in-service level blocks itself and all lower levels.
- INTA edges: inta_rise = inta & ~inta_q, where inta_q is a registered copy of inta; inta_fall likewise.
- FSM IDLE: int_out=0. If any eligible request exists -> PEND, with int_out=1 from the next cycle (1-cycle latency).
- FSM PEND: int_out held at 1 even if irr drops.
  - On inta_rise, the winner is recomputed from irr in that same cycle.
  - Valid winner: isr[w] set, reset_irr_bit pulses the following cycle, cur_level=w.
  - No winner: cur_level=SPURIOUS_LEVEL, isr unchanged, no reset_irr_bit pulse.
  - int_out=0; go ACK1.
- FSM ACK1: on inta_rise -> data_out={vector_base, cur_level}, data_en=1 on the next cycle; go ACK2.
- FSM ACK2: data_en stays 1 while inta=1. On inta_fall: data_en=0, data_out=0; if aeoi and the cycle was not spurious, clear isr[cur_level]; go IDLE.
- IDLE re-evaluates eligibility on the following cycle. Back-to-back interrupts therefore need at least 1 idle cycle.
- Non-specific EOI: clears the highest-priority set isr bit. No effect if isr==0.
- Specific EOI: clears isr[eoi_level], even if that bit is already 0.
- Rotate: with rotate=1, lowest_prio := level cleared. If no bit was cleared, lowest_prio is unchanged.
- EOI is accepted in any state.
- Same-cycle EOI and ISR set: clear is applied first, then set. A set of the same bit wins.
- Same-cycle EOI and auto-EOI: both clears apply.
- inta_rise in IDLE: ignored; no state change, no outputs.
- An irr change between INT assertion and the first INTA changes the winner; there is no latch before INTA.

Test Plan:
- Basic cycle: reset, irr=8'h04, vector_base=5'h08 -> int_out=1; INTA1 -> isr=8'h04, reset_irr_bit 1 cycle, int_out=0; INTA2 -> data_out=8'h42, data_en=1 until inta falls.
- Nesting: isr=8'h08 held. irr=8'h10 -> int_out stays 0. irr=8'h02 -> full cycle, isr=8'h0A. Non-specific EOI -> isr=8'h08.
- Rotation: isr=8'h01, eoi=1, rotate=1, non-specific -> isr=0, lowest_prio=0. Then irr=8'h81 -> winner IR1? No, irr bit 1 is 0; winner is IR7? No, IR1 > IR7 in order but IR1 absent; IR0 is now lowest, so winner is IR7, data_out low bits=3'd7.
- Spurious: irr=8'h20 raises INT, irr dropped to 0 before INTA1 -> cur_level=7, isr=0, no reset_irr_bit, vector low bits=3'd7.
- Auto-EOI and collision: aeoi=1 with irr=8'h01 -> isr returns to 0 on inta_fall. Specific EOI for level 0 in the same cycle as INTA1 -> isr[0]=1 after the edge.
- Mid-op reset: reset asserted in ACK1 -> next cycle int_out=0, isr=0, data_en=0, lowest_prio=7; a following inta pulse produces no output.
